// File: rtl/debounce_pkg.sv
// Shared timing constants and helpers for the push-button debouncers.
// Defaults assume the 50 MHz lab board clock.
package debounce_pkg;

  localparam int CLK_HZ      = 50_000_000;
  localparam int DEBOUNCE_MS = 20;
  localparam int LONG_MS     = 1000;

  function automatic int ms_to_cycles(
    input int clk_hz,
    input int ms
  );
    return (clk_hz / 1000) * ms;
  endfunction

  function automatic int max_int(
    input int a,
    input int b
  );
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounced button: 2-flop synchroniser, stability counter,
// hold counter and registered press/release/long-press pulses.
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int CNT_WIDTH     = 24,
  parameter int HOLD_WIDTH    = 26,
  parameter int STABLE_CYCLES = 1_000_000,
  parameter int LONG_CYCLES   = 50_000_000,
  parameter int ACTIVE_LOW    = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic button,
  output logic button_state,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_press
);

  localparam logic IDLE = (ACTIVE_LOW != 0);

  localparam logic [CNT_WIDTH-1:0] STABLE_LAST =
    CNT_WIDTH'(STABLE_CYCLES - 1);
  localparam logic [HOLD_WIDTH-1:0] LONG_LAST =
    HOLD_WIDTH'(LONG_CYCLES - 1);
  localparam logic [HOLD_WIDTH-1:0] LONG_MAX =
    HOLD_WIDTH'(LONG_CYCLES);

  logic                  sync1_q, sync1_d;
  logic                  sync2_q, sync2_d;
  logic                  state_q, state_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic [HOLD_WIDTH-1:0] hold_q, hold_d;
  logic                  press_q, press_d;
  logic                  rel_q, rel_d;
  logic                  long_q, long_d;
  logic                  s;

  always_comb begin
    sync1_d = button;
    sync2_d = sync1_q;
    s       = sync2_q ^ IDLE;
    state_d = state_q;
    cnt_d   = '0;
    press_d = 1'b0;
    rel_d   = 1'b0;
    long_d  = 1'b0;
    hold_d  = hold_q;

    if (s != state_q) begin
      if (cnt_q == STABLE_LAST) begin
        state_d = ~state_q;
        press_d = ~state_q;
        rel_d   = state_q;
      end else begin
        cnt_d = cnt_q + CNT_WIDTH'(1);
      end
    end

    // Saturating hold count; the LONG-1 -> LONG step fires once.
    if (!state_q) begin
      hold_d = '0;
    end else if (hold_q != LONG_MAX) begin
      hold_d = hold_q + HOLD_WIDTH'(1);
    end
    long_d = state_q && (hold_q == LONG_LAST);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= IDLE;
      sync2_q <= IDLE;
      state_q <= 1'b0;
      cnt_q   <= '0;
      hold_q  <= '0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
      long_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
      press_q <= press_d;
      rel_q   <= rel_d;
      long_q  <= long_d;
    end
  end

  assign button_state  = state_q;
  assign press_pulse   = press_q;
  assign release_pulse = rel_q;
  assign long_press    = long_q;

endmodule

// File: rtl/debouncer_multi.sv
// Multi-channel push-button debouncer: CHANNELS independent
// debounce_channel instances sharing one clock and reset.
module debouncer_multi
  import debounce_pkg::*;
#(
  parameter int CHANNELS      = 4,
  parameter int CNT_WIDTH     = 24,
  parameter int STABLE_CYCLES = ms_to_cycles(CLK_HZ, DEBOUNCE_MS),
  parameter int LONG_CYCLES   = ms_to_cycles(CLK_HZ, LONG_MS),
  parameter int ACTIVE_LOW    = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] button,
  output logic [CHANNELS-1:0] button_state,
  output logic [CHANNELS-1:0] press_pulse,
  output logic [CHANNELS-1:0] release_pulse,
  output logic [CHANNELS-1:0] long_press
);

  // Hold counter grows past CNT_WIDTH only if the 1 s default needs it.
  localparam int HOLD_WIDTH =
    max_int(CNT_WIDTH, $clog2(LONG_CYCLES + 1));

  if (CHANNELS < 1) begin : g_chk_ch
    $error("CHANNELS must be >= 1");
  end
  if (STABLE_CYCLES < 1) begin : g_chk_st
    $error("STABLE_CYCLES must be >= 1");
  end
  if (longint'(STABLE_CYCLES) >
      (longint'(1) << CNT_WIDTH)) begin : g_chk_w
    $error("STABLE_CYCLES does not fit CNT_WIDTH");
  end
  if (LONG_CYCLES <= STABLE_CYCLES) begin : g_chk_lg
    $error("LONG_CYCLES must exceed STABLE_CYCLES");
  end
  if (ACTIVE_LOW != 0 && ACTIVE_LOW != 1) begin : g_chk_al
    $error("ACTIVE_LOW must be 0 or 1");
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    debounce_channel #(
      .CNT_WIDTH     (CNT_WIDTH),
      .HOLD_WIDTH    (HOLD_WIDTH),
      .STABLE_CYCLES (STABLE_CYCLES),
      .LONG_CYCLES   (LONG_CYCLES),
      .ACTIVE_LOW    (ACTIVE_LOW)
    ) u_ch (
      .clk           (clk),
      .rst           (rst),
      .button        (button[i]),
      .button_state  (button_state[i]),
      .press_pulse   (press_pulse[i]),
      .release_pulse (release_pulse[i]),
      .long_press    (long_press[i])
    );
  end

endmodule

// File: tb/tb_debouncer_multi.sv
// Scoreboard bench: an active-high and an active-low instance run the
// same (inverted) stimulus and must pulse on identical cycles.
module tb_debouncer_multi;

  typedef struct {
    int         cyc;
    logic [1:0] pp;
    logic [1:0] rp;
    logic [1:0] lp;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] btn = 2'b11;
  logic [1:0] btn_n;
  logic [1:0] st0, pp0, rp0, lp0;
  logic [1:0] st1, pp1, rp1, lp1;

  int  cyc   = 0;
  int  total = 0;
  int  bad   = 0;
  ev_t q [2][$];

  assign btn_n = ~btn;

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  debouncer_multi #(
    .CHANNELS(2), .CNT_WIDTH(8), .STABLE_CYCLES(4),
    .LONG_CYCLES(16), .ACTIVE_LOW(0)
  ) dut0 (
    .clk(clk), .rst(rst), .button(btn),
    .button_state(st0), .press_pulse(pp0),
    .release_pulse(rp0), .long_press(lp0)
  );

  debouncer_multi #(
    .CHANNELS(2), .CNT_WIDTH(8), .STABLE_CYCLES(4),
    .LONG_CYCLES(16), .ACTIVE_LOW(1)
  ) dut1 (
    .clk(clk), .rst(rst), .button(btn_n),
    .button_state(st1), .press_pulse(pp1),
    .release_pulse(rp1), .long_press(lp1)
  );

  task automatic expect_ev(input int c, input logic [1:0] p,
                           input logic [1:0] r, input logic [1:0] l);
    for (int d = 0; d < 2; d++) begin
      int idx;
      ev_t e;
      idx = -1;
      for (int i = 0; i < q[d].size(); i++)
        if (q[d][i].cyc == c) idx = i;
      if (idx >= 0) begin
        q[d][idx].pp = q[d][idx].pp | p;
        q[d][idx].rp = q[d][idx].rp | r;
        q[d][idx].lp = q[d][idx].lp | l;
      end else begin
        e.cyc = c; e.pp = p; e.rp = r; e.lp = l;
        q[d].push_back(e);
      end
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [7:0] act,
                     input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cyc %0d: got %h want %h",
               name, cyc, act, exp);
    end
  endtask

  task automatic chk_state(input string name, input logic [1:0] exp);
    chk({name, "_al0"}, {6'd0, st0}, {6'd0, exp});
    chk({name, "_al1"}, {6'd0, st1}, {6'd0, exp});
  endtask

  task automatic chk_zero(input string name);
    chk({name, "_al0"}, {st0, pp0, rp0, lp0}, 8'h00);
    chk({name, "_al1"}, {st1, pp1, rp1, lp1}, 8'h00);
  endtask

  task automatic mon(input int d, input logic [1:0] st,
                     input logic [1:0] p, input logic [1:0] r,
                     input logic [1:0] l);
    int idx;
    idx = -1;
    for (int i = 0; i < q[d].size(); i++)
      if (q[d][i].cyc == cyc) idx = i;
    total++;
    if (idx < 0) begin
      bad++;
      $display("FAIL unexpected dut%0d cyc %0d: pp=%b rp=%b lp=%b",
               d, cyc, p, r, l);
    end else begin
      if (p !== q[d][idx].pp || r !== q[d][idx].rp ||
          l !== q[d][idx].lp) begin
        bad++;
        $display("FAIL pulses dut%0d cyc %0d: got %b/%b/%b want %b/%b/%b",
                 d, cyc, p, r, l, q[d][idx].pp, q[d][idx].rp,
                 q[d][idx].lp);
      end
      q[d].delete(idx);
    end
    total++;
    if ((p & r) != 2'b00 || (st & p) != p || (st & r) != 2'b00) begin
      bad++;
      $display("FAIL coherence dut%0d cyc %0d: st=%b pp=%b rp=%b want pp&rp=0 pp<=st rp&st=0",
               d, cyc, st, p, r);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if ((pp0 | rp0 | lp0) != 2'b00) mon(0, st0, pp0, rp0, lp0);
    if ((pp1 | rp1 | lp1) != 2'b00) mon(1, st1, pp1, rp1, lp1);
  end

  initial begin
    int c;
    // 1: held through reset, seen as a fresh press
    step(3);
    chk_zero("reset");
    rst = 1'b0;
    expect_ev(cyc + 6, 2'b11, 2'b00, 2'b00);
    step(5);
    chk_state("pre_press", 2'b00);
    step(3);
    chk_state("post_reset_press", 2'b11);
    btn = 2'b00;
    expect_ev(cyc + 6, 2'b00, 2'b11, 2'b00);
    step(12);
    chk_state("released", 2'b00);

    // 2: bounce on ch0, highs of 1, 2, 3 cycles
    btn[0] = 1'b1; step(1);
    btn[0] = 1'b0; step(2);
    btn[0] = 1'b1; step(2);
    btn[0] = 1'b0; step(2);
    btn[0] = 1'b1; step(3);
    btn[0] = 1'b0; step(2);
    chk_state("bounce", 2'b00);
    btn[0] = 1'b1;
    expect_ev(cyc + 6, 2'b01, 2'b00, 2'b00);
    step(8);
    chk_state("bounce_settled", 2'b01);
    btn[0] = 1'b0;
    expect_ev(cyc + 6, 2'b00, 2'b01, 2'b00);
    step(12);

    // 3: long press on ch1
    btn[1] = 1'b1;
    c = cyc;
    expect_ev(c + 6, 2'b10, 2'b00, 2'b00);
    expect_ev(c + 22, 2'b00, 2'b00, 2'b10);
    step(10);
    chk_state("long_held", 2'b10);
    step(20);
    btn[1] = 1'b0;
    expect_ev(cyc + 6, 2'b00, 2'b10, 2'b00);
    step(12);
    chk_state("long_released", 2'b00);

    // 4: short press on ch0, no long_press
    btn[0] = 1'b1;
    expect_ev(cyc + 6, 2'b01, 2'b00, 2'b00);
    step(10);
    btn[0] = 1'b0;
    expect_ev(cyc + 6, 2'b00, 2'b01, 2'b00);
    step(30);

    // 5: simultaneous press, ch0 release leaves ch1 hold intact
    btn = 2'b11;
    c = cyc;
    expect_ev(c + 6, 2'b11, 2'b00, 2'b00);
    expect_ev(c + 22, 2'b00, 2'b00, 2'b10);
    step(8);
    btn[0] = 1'b0;
    expect_ev(cyc + 6, 2'b00, 2'b01, 2'b00);
    step(17);
    chk_state("indep", 2'b10);
    btn[1] = 1'b0;
    expect_ev(cyc + 6, 2'b00, 2'b10, 2'b00);
    step(12);

    // 6: reset at hold=10 kills the pending long_press
    btn[1] = 1'b1;
    expect_ev(cyc + 6, 2'b10, 2'b00, 2'b00);
    step(16);
    chk_state("pre_mid_rst", 2'b10);
    rst = 1'b1;
    #1;
    chk_zero("mid_rst");
    btn = 2'b00;
    step(2);
    rst = 1'b0;
    step(30);
    chk_state("after_mid_rst", 2'b00);

    step(5);
    for (int d = 0; d < 2; d++) begin
      total++;
      if (q[d].size() != 0) begin
        bad++;
        $display("FAIL missing dut%0d: %0d events left, want 0 (first cyc %0d)",
                 d, q[d].size(), q[d][0].cyc);
      end
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
